// File: rtl/md_unit.sv
// md_unit: multiply/divide unit holding the HI/LO register pair.
//
// Ports:
//   clk    - the only clock; all state updates on its rising edge
//   reset  - asynchronous, active-high; clears state, count, operands, HI, LO
//   start  - qualifies op/srcA/srcB for one cycle (only honoured in IDLE)
//   op     - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   srcA   - rs operand (dividend / multiplicand / MTHI-MTLO data)
//   srcB   - rt operand (divisor / multiplier)
//   busy   - high while a multiply or divide is in flight
//   HI, LO - registered result registers
//
// A multiply or divide latches its operands, then counts down MULT_CYCLES
// or DIV_CYCLES busy cycles. The result is written into HI/LO on the edge
// that ends the last busy cycle; a zero divisor leaves HI/LO untouched.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [2:0]    op_reg, op_next;
    logic [31:0]   a_reg, a_next;
    logic [31:0]   b_reg, b_next;
    logic [31:0]   hi_reg, hi_next;
    logic [31:0]   lo_reg, lo_next;

    // Datapath, evaluated from the latched operands only.
    logic        is_signed;
    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, uq, ur, quot, rem;

    always_comb begin
        is_signed = (op_reg == OP_MULT) || (op_reg == OP_DIV);

        // Low 64 bits of the sign-extended product equal the signed product.
        a_ext = is_signed ? {{32{a_reg[31]}}, a_reg} : {32'd0, a_reg};
        b_ext = is_signed ? {{32{b_reg[31]}}, b_reg} : {32'd0, b_reg};
        prod  = a_ext * b_ext;

        // Signed division via magnitudes avoids the INT_MIN / -1 overflow:
        // |0x80000000| is 0x80000000 unsigned, giving quotient 0x80000000.
        a_mag = (is_signed && a_reg[31]) ? (32'd0 - a_reg) : a_reg;
        b_mag = (is_signed && b_reg[31]) ? (32'd0 - b_reg) : b_reg;
        if (b_mag != 32'd0) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end else begin
            uq = 32'd0;
            ur = 32'd0;
        end
        quot = (is_signed && (a_reg[31] ^ b_reg[31])) ? (32'd0 - uq) : uq;
        rem  = (is_signed && a_reg[31]) ? (32'd0 - ur) : ur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            op_next    = op;
                            a_next     = srcA;
                            b_next     = srcB;
                            count_next = CW'(MULT_CYCLES);
                            state_next = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_next    = op;
                            a_next     = srcA;
                            b_next     = srcB;
                            count_next = CW'(DIV_CYCLES);
                            state_next = BUSY;
                        end
                        OP_MTHI: hi_next = srcA;
                        OP_MTLO: lo_next = srcA;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                // start is deliberately not looked at here.
                if (count_reg <= CW'(1)) begin
                    state_next = IDLE;
                    count_next = '0;
                    if (op_reg == OP_MULT || op_reg == OP_MULTU) begin
                        hi_next = prod[63:32];
                        lo_next = prod[31:0];
                    end else if (b_reg != 32'd0) begin
                        hi_next = rem;
                        lo_next = quot;
                    end
                end else begin
                    count_next = count_reg - CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg == BUSY);
    assign HI   = hi_reg;
    assign LO   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: directed cases plus randomized operations checked
// against an arithmetic reference model of HI/LO and busy timing.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srcA, srcB;
    logic        busy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .srcA(srcA), .srcB(srcB), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'd0: begin q = sa * sb; p = q; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
            3'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb; p = q; lo_m = p[31:0]; p = r; hi_m = p[31:0];
            end
            3'd3: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
    endtask

    // Issue one op at the current negedge and follow it to completion.
    // inject > 0 drives a random start in that busy cycle, which must be ignored.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int inject, input logic [31:0] inj_data);
        int lat;
        lat = (o <= 3'd1) ? MC : (o <= 3'd3) ? DC : 0;
        start = 1'b1; op = o; srcA = a; srcB = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            chk("busy_high", {31'd0, busy}, 32'd1);
            chk("hi_hold", HI, hi_m);
            chk("lo_hold", LO, lo_m);
            srcA = $urandom; srcB = $urandom;
            if (i == inject) begin
                start = 1'b1; op = 3'($urandom_range(0, 7)); srcA = inj_data;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        model(o, a, b);
        chk("busy_low", {31'd0, busy}, 32'd0);
        chk("hi_result", HI, hi_m);
        chk("lo_result", LO, lo_m);
        $display("op=%0d a=%h b=%h -> HI=%h LO=%h", o, a, b, HI, LO);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; srcA = 32'd0; srcB = 32'd0;
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        // start is ignored while reset is held
        start = 1'b1; op = 3'd4; srcA = 32'h12345678;
        @(negedge clk); @(negedge clk);
        chk("reset_ignores_start", HI, 32'd0);
        start = 1'b0; reset = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 0, 0);
        chk("mult_hi_const", HI, 32'hFFFFFFFF);
        chk("mult_lo_const", LO, 32'hFFFFFFFA);
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, 0, 0);
        chk("multu_hi_const", HI, 32'h00000002);
        chk("multu_lo_const", LO, 32'hFFFFFFFA);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0);
        chk("div_lo_const", LO, 32'hFFFFFFFD);
        chk("div_hi_const", HI, 32'hFFFFFFFF);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        chk("div_ovf_lo", LO, 32'h80000000);
        chk("div_ovf_hi", HI, 32'h00000000);

        run_op(3'd4, 32'h11111111, 32'd0, 0, 0);
        run_op(3'd5, 32'h22222222, 32'd0, 0, 0);
        run_op(3'd3, 32'd5, 32'd0, 0, 0);
        chk("divz_hi_const", HI, 32'h11111111);
        chk("divz_lo_const", LO, 32'h22222222);

        // Reserved ops and idle cycles leave HI/LO alone.
        run_op(3'd6, 32'hAAAAAAAA, 32'd1, 0, 0);
        run_op(3'd7, 32'hBBBBBBBB, 32'd1, 0, 0);
        repeat (3) @(negedge clk);
        chk("idle_hi", HI, hi_m);
        chk("idle_lo", LO, lo_m);

        // Start while busy: clear HI to 0 first, then MULTU 2*3.
        run_op(3'd4, 32'd0, 32'd0, 0, 0);
        run_op(3'd1, 32'd2, 32'd3, 2, 32'hDEADBEEF);
        chk("swb_hi_const", HI, 32'd0);
        chk("swb_lo_const", LO, 32'd6);

        // Reset in busy cycle 4 of DIV 100/7.
        start = 1'b1; op = 3'd2; srcA = 32'd100; srcB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midop_busy", {31'd0, busy}, 32'd0);
        chk("midop_hi", HI, 32'd0);
        chk("midop_lo", LO, 32'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DC + 3; i++) begin
            @(negedge clk);
            chk("post_reset_busy", {31'd0, busy}, 32'd0);
            chk("post_reset_hi", HI, 32'd0);
            chk("post_reset_lo", LO, 32'd0);
        end

        // Randomized back-to-back operations, including corner operands.
        for (int n = 0; n < 60; n++) begin
            logic [2:0] o;
            logic [31:0] a, b;
            int sel;
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            else if (sel == 2) b = {28'd0, 4'($urandom)};
            run_op(o, a, b, (n % 3 == 0) ? 1 + (n % 4) : 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
